trap_ret: RTL and testbench
===========================

# trap_ret

Machine-mode trap-return sequencer. On a decoded `mret`, it walks the shared CSR port to restore `mstatus` (MIE←MPIE, MPIE←1, MPP←M) and fetch `mepc`, then issues a one-cycle redirect to the return address. It is the exit-side counterpart of the trap-entry FSM and sits beside it between idex and the CSR file. The shared CSR-port mux selects this block whenever `ret_busy_o` is high.

## Interface
Parameters:
- `IALIGN`, default 32: instruction alignment in bits, 32 or 16. Clears `mepc[1:0]` (32) or `mepc[0]` (16) on jump.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `mret_i`  in  1  idex has decoded `mret`; held while the instruction is stalled.
- `trap_busy_i`  in  1  trap-entry FSM not idle; trap entry has priority.
- `csr_rdata_i`  in  32  CSR read data, combinational from `csr_addr_o`.
- `csr_addr_o`  out  12  CSR address.
- `csr_wdata_o`  out  32  CSR write data.
- `csr_we_o`  out  1  CSR write strobe.
- `pc_n_i`  in  32  idex next-PC.
- `pc_n_o`  out  32  arbitrated next-PC.
- `ret_jump_o`  out  1  redirect pulse.
- `ret_busy_o`  out  1  pipeline hold and CSR-port ownership.

## Operation
- FSM states: IDLE, RMST, WMST, RMEP, JUMP.
- IDLE:
  - Goes to RMST when `mret_i & ~trap_busy_i`; otherwise stays.
  - While `trap_busy_i`, `mret_i` is ignored entirely.
- RMST: `csr_addr_o=12'h300`; `mst_q <= csr_rdata_i`; → WMST.
- WMST: `csr_addr_o=12'h300`, `csr_we_o=1`, `csr_wdata_o` = `mst_q` with:
  - bit3 ← `mst_q[7]`
  - bit7 ← 1
  - bits12:11 ← 2'b11
  - all other bits unchanged
  - → RMEP.
- RMEP: `csr_addr_o=12'h341`; `mepc_q <= csr_rdata_i`; → JUMP.
- JUMP: `ret_jump_o=1`; `pc_n_o` = `mepc_q` with low bits cleared per `IALIGN`; → IDLE unconditionally. `mret_i` is not sampled in JUMP.
- Default outputs in every state unless set above:
  - `csr_addr_o=0`, `csr_wdata_o=0`, `csr_we_o=0`
  - `ret_jump_o=0`, `pc_n_o=pc_n_i`
- `ret_busy_o = (state!=IDLE) | (mret_i & ~trap_busy_i)`.
- `mst_q` and `mepc_q` are 32-bit registers, reset to 0, loaded only in their read state.
- Exceptions are not detected here; `mepc` is used as read (no range check).

## Timing
- Cycle-level sequence, with cycle 0 = IDLE and `mret_i=1`, `trap_busy_i=0`:
  - cycles 1–4: RMST, WMST, RMEP, JUMP.
  - cycle 5: IDLE.
- `ret_busy_o` is high for cycles 0–4 (5 cycles).
- Exactly one CSR write occurs, in cycle 2.
- The redirect occurs in cycle 4, and `ret_jump_o` is high for exactly 1 cycle.
- All outputs are combinational from state and registers. There is no input-to-output path except `pc_n_i`→`pc_n_o` and `mret_i`/`trap_busy_i`→`ret_busy_o`.
- Simultaneous `trap_busy_i` and `mret_i` in IDLE: trap wins; no CSR access from this block, and `ret_busy_o=0`.
- `trap_busy_i` rising after leaving IDLE is ignored; trap entry must not start while `ret_busy_o=1`. The integration mux enforces this.
- The cycle after JUMP, `mret_i` reflects the redirected instruction. A new assertion there starts a new sequence.
- Reset at any point:
  - state→IDLE and registers→0 immediately.
  - All outputs return to defaults (`csr_we_o=0`, `ret_jump_o=0`, `pc_n_o=pc_n_i`, `ret_busy_o` follows the formula).
  - A completed WMST write is not undone.

## Structure
- Shared package (`defines.v`), using the existing `RegBus`/`CsrAddrBus`/`InstAddrBus` widths:
  - CSR addresses `CSR_MSTATUS=12'h300`, `CSR_MEPC=12'h341`
  - mstatus bit positions MIE=3, MPIE=7, MPP=12:11
- State encoding: localparams inside the module, 3-bit.
- Single module; no sub-module is natural.

## Test plan
- `mstatus=32'h0000_0080`, `mepc=32'h0000_0104`, pulse-held `mret_i` → cycle 2 write `32'h0000_1888` to 0x300; cycle 4 `ret_jump_o=1`, `pc_n_o=32'h0000_0104`; `ret_busy_o` high for 5 cycles.
- `mstatus=32'h0000_0008`, `mepc=32'h8000_0000` → write `32'h0000_1880` (MIE cleared); jump to `32'h8000_0000`.
- `mepc=32'h0000_0207`, `IALIGN=32` → `pc_n_o=32'h0000_0204`; with `IALIGN=16` → `32'h0000_0206`.
- `mret_i=1` with `trap_busy_i=1` for 3 cycles → `csr_we_o=0`, `csr_addr_o=0`, `ret_busy_o=0` throughout; RMST on the cycle after `trap_busy_i` falls.
- `rst` asserted during WMST → next edge state IDLE; `csr_we_o=0`; no `ret_jump_o`; `pc_n_o=pc_n_i`.
- `mret_i` held through JUMP and deasserted in cycle 5 → exactly one sequence. Held high in cycle 5 → second sequence starts, with RMST at cycle 6.

Source files
------------

// File: rtl/trap_ret_pkg.sv
// trap_ret_pkg: shared widths, CSR addresses, mstatus field positions,
// the trap-return FSM state type and helpers used by the mret sequencer.
package trap_ret_pkg;

  // Bus widths inherited from the core-wide definitions.
  localparam int unsigned RegBus      = 32;
  localparam int unsigned CsrAddrBus  = 12;
  localparam int unsigned InstAddrBus = 32;

  // CSR addresses touched by the return sequence.
  localparam logic [CsrAddrBus-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CsrAddrBus-1:0] CSR_MEPC    = 12'h341;

  // mstatus field positions.
  localparam int unsigned MST_MIE    = 3;
  localparam int unsigned MST_MPIE   = 7;
  localparam int unsigned MST_MPP_LO = 11;
  localparam int unsigned MST_MPP_HI = 12;

  // Trap-return sequencer states (3-bit encoding).
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RMST = 3'd1,
    S_WMST = 3'd2,
    S_RMEP = 3'd3,
    S_JUMP = 3'd4
  } ret_state_e;

  // mstatus image written back on mret: MIE <- MPIE, MPIE <- 1, MPP <- M.
  function automatic logic [RegBus-1:0] mret_mstatus(input logic [RegBus-1:0] mst);
    logic [RegBus-1:0] r;
    r                         = mst;
    r[MST_MIE]                = mst[MST_MPIE];
    r[MST_MPIE]               = 1'b1;
    r[MST_MPP_HI:MST_MPP_LO]  = 2'b11;
    return r;
  endfunction

  // Return address with the bits below the instruction alignment cleared.
  function automatic logic [InstAddrBus-1:0] align_pc(input logic [InstAddrBus-1:0] pc,
                                                      input int unsigned ialign);
    if (ialign == 16)
      return {pc[InstAddrBus-1:1], 1'b0};
    else
      return {pc[InstAddrBus-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/trap_ret_if.sv
// trap_ret_if: groups the idex handshake, the shared CSR port and the
// next-PC arbitration signals of the trap-return sequencer.
//   master : the sequencer (drives CSR address/data/strobe, pc_n_o,
//            ret_jump_o, ret_busy_o)
//   slave  : the surrounding pipeline / CSR file
interface trap_ret_if;
  import trap_ret_pkg::*;

  logic                   mret_i;       // idex decoded mret (held while stalled)
  logic                   trap_busy_i;  // trap-entry FSM not idle
  logic [RegBus-1:0]      csr_rdata_i;  // CSR read data, combinational from address
  logic [CsrAddrBus-1:0]  csr_addr_o;   // CSR address
  logic [RegBus-1:0]      csr_wdata_o;  // CSR write data
  logic                   csr_we_o;     // CSR write strobe
  logic [InstAddrBus-1:0] pc_n_i;       // idex next-PC
  logic [InstAddrBus-1:0] pc_n_o;       // arbitrated next-PC
  logic                   ret_jump_o;   // redirect pulse
  logic                   ret_busy_o;   // pipeline hold / CSR-port ownership

  modport master (
    input  mret_i, trap_busy_i, csr_rdata_i, pc_n_i,
    output csr_addr_o, csr_wdata_o, csr_we_o, pc_n_o, ret_jump_o, ret_busy_o
  );

  modport slave (
    output mret_i, trap_busy_i, csr_rdata_i, pc_n_i,
    input  csr_addr_o, csr_wdata_o, csr_we_o, pc_n_o, ret_jump_o, ret_busy_o
  );

endinterface

// File: rtl/trap_ret.sv
// trap_ret: machine-mode trap-return sequencer.
// On a decoded mret (and no trap entry in progress) it reads mstatus,
// writes back the restored image, reads mepc and issues a one-cycle
// redirect to the aligned return address.
// Ports:
//   clk  - core clock
//   rst  - asynchronous active-high reset
//   bus  - trap_ret_if.master: mret_i/trap_busy_i/pc_n_i in, shared CSR
//          port, pc_n_o, ret_jump_o, ret_busy_o
// Parameter:
//   IALIGN - instruction alignment in bits (32 or 16)
module trap_ret
  import trap_ret_pkg::*;
#(
  parameter int unsigned IALIGN = 32
) (
  input  logic        clk,
  input  logic        rst,
  trap_ret_if.master  bus
);

  ret_state_e             state_q;
  ret_state_e             state_n;
  logic [RegBus-1:0]      mst_q;
  logic [InstAddrBus-1:0] mepc_q;
  logic                   start;

  // Trap entry has priority: a coincident mret is ignored entirely.
  assign start = bus.mret_i & ~bus.trap_busy_i;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_n;
  end

  // Captured CSR values, each loaded only in its read state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mst_q  <= '0;
      mepc_q <= '0;
    end else begin
      if (state_q == S_RMST)
        mst_q <= bus.csr_rdata_i;
      if (state_q == S_RMEP)
        mepc_q <= bus.csr_rdata_i;
    end
  end

  // Next-state logic; mret_i is only sampled in IDLE
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_n = S_RMST;
      S_RMST:  state_n = S_WMST;
      S_WMST:  state_n = S_RMEP;
      S_RMEP:  state_n = S_JUMP;
      S_JUMP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.csr_addr_o  = '0;
    bus.csr_wdata_o = '0;
    bus.csr_we_o    = 1'b0;
    bus.ret_jump_o  = 1'b0;
    bus.pc_n_o      = bus.pc_n_i;
    unique case (state_q)
      S_RMST: bus.csr_addr_o = CSR_MSTATUS;
      S_WMST: begin
        bus.csr_addr_o  = CSR_MSTATUS;
        bus.csr_we_o    = 1'b1;
        bus.csr_wdata_o = mret_mstatus(mst_q);
      end
      S_RMEP: bus.csr_addr_o = CSR_MEPC;
      S_JUMP: begin
        bus.ret_jump_o = 1'b1;
        bus.pc_n_o     = align_pc(mepc_q, IALIGN);
      end
      default: ;
    endcase
  end

  // Busy asserts in the same cycle mret is accepted so idex holds at once.
  assign bus.ret_busy_o = (state_q != S_IDLE) | start;

endmodule

// File: tb/tb_trap_ret.sv
module tb_trap_ret;

  typedef struct {
    int unsigned cyc;
    logic [31:0] val;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        mret;
  logic        trap_busy;
  logic [31:0] csr_mst;
  logic [31:0] csr_mepc;
  int unsigned cyc;
  int unsigned checks;
  int unsigned errors;

  exp_t wq32[$];
  exp_t jq32[$];
  exp_t wq16[$];
  exp_t jq16[$];

  trap_ret_if if32 ();
  trap_ret_if if16 ();

  trap_ret #(.IALIGN(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32));
  trap_ret #(.IALIGN(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

  // Stimulus fan-out and a trivial read-only CSR file per instance
  assign if32.mret_i      = mret;
  assign if16.mret_i      = mret;
  assign if32.trap_busy_i = trap_busy;
  assign if16.trap_busy_i = trap_busy;
  assign if32.pc_n_i      = 32'hC0DE_0000 ^ cyc;
  assign if16.pc_n_i      = 32'hC0DE_0000 ^ cyc;
  assign if32.csr_rdata_i = (if32.csr_addr_o == 12'h300) ? csr_mst :
                            (if32.csr_addr_o == 12'h341) ? csr_mepc : 32'h0;
  assign if16.csr_rdata_i = (if16.csr_addr_o == 12'h300) ? csr_mst :
                            (if16.csr_addr_o == 12'h341) ? csr_mepc : 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (if32.csr_we_o) begin
      if (wq32.size() == 0) check("w32_unexpected", 32'(if32.csr_wdata_o), 32'hFFFF_FFFF);
      else begin
        e = wq32.pop_front();
        check("w32_cycle", cyc, e.cyc);
        check("w32_addr", 32'(if32.csr_addr_o), 32'h300);
        check("w32_data", if32.csr_wdata_o, e.val);
      end
    end
    if (if16.csr_we_o) begin
      if (wq16.size() == 0) check("w16_unexpected", 32'(if16.csr_wdata_o), 32'hFFFF_FFFF);
      else begin
        e = wq16.pop_front();
        check("w16_cycle", cyc, e.cyc);
        check("w16_data", if16.csr_wdata_o, e.val);
      end
    end
    if (if32.ret_jump_o) begin
      if (jq32.size() == 0) check("j32_unexpected", if32.pc_n_o, 32'hFFFF_FFFF);
      else begin
        e = jq32.pop_front();
        check("j32_cycle", cyc, e.cyc);
        check("j32_pc", if32.pc_n_o, e.val);
      end
    end else
      check("pass32_pc", if32.pc_n_o, 32'hC0DE_0000 ^ cyc);
    if (if16.ret_jump_o) begin
      if (jq16.size() == 0) check("j16_unexpected", if16.pc_n_o, 32'hFFFF_FFFF);
      else begin
        e = jq16.pop_front();
        check("j16_cycle", cyc, e.cyc);
        check("j16_pc", if16.pc_n_o, e.val);
      end
    end else
      check("pass16_pc", if16.pc_n_o, 32'hC0DE_0000 ^ cyc);
  end

  task automatic expect_seq(input int unsigned c0, input logic [31:0] w,
                            input logic [31:0] pc32, input logic [31:0] pc16);
    wq32.push_back('{c0 + 2, w});
    wq16.push_back('{c0 + 2, w});
    jq32.push_back('{c0 + 4, pc32});
    jq16.push_back('{c0 + 4, pc16});
  endtask

  // One mret held for cycles 0..4, dropped in cycle 5. Optionally raise
  // trap_busy during WMST to show it is ignored once the sequence runs.
  task automatic run_seq(input logic [31:0] mst, input logic [31:0] mepc,
                         input logic [31:0] w, input logic [31:0] pc32,
                         input logic [31:0] pc16, input bit trap_mid);
    int unsigned busy_cnt;
    csr_mst  = mst;
    csr_mepc = mepc;
    expect_seq(cyc, w, pc32, pc16);
    mret     = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (trap_mid) trap_busy = (i == 2);
      @(negedge clk);
      if (if32.ret_busy_o) busy_cnt++;
      if (i == 1) check("rmst_addr", 32'(if32.csr_addr_o), 32'h300);
      if (i == 3) check("rmep_addr", 32'(if32.csr_addr_o), 32'h341);
      step();
    end
    mret      = 1'b0;
    trap_busy = 1'b0;
    @(negedge clk);
    if (if32.ret_busy_o) busy_cnt++;
    check("busy_len", busy_cnt, 5);
    step();
  endtask

  initial begin
    cyc       = 0;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    mret      = 1'b0;
    trap_busy = 1'b0;
    csr_mst   = 32'h0;
    csr_mepc  = 32'h0;

    @(negedge clk);
    check("rst_we", 32'(if32.csr_we_o), 32'h0);
    check("rst_addr", 32'(if32.csr_addr_o), 32'h0);
    check("rst_busy", 32'(if32.ret_busy_o), 32'h0);
    check("rst_jump", 32'(if32.ret_jump_o), 32'h0);
    step();
    rst = 1'b0;
    step();

    run_seq(32'h0000_0080, 32'h0000_0104, 32'h0000_1888, 32'h0000_0104, 32'h0000_0104, 1'b0);
    run_seq(32'h0000_0008, 32'h8000_0000, 32'h0000_1880, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_seq(32'h0000_0000, 32'h0000_0207, 32'h0000_1880, 32'h0000_0204, 32'h0000_0206, 1'b0);
    run_seq(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'hFFFF_FFFE, 1'b1);
    run_seq(32'hFFFF_FF77, 32'h1234_5672, 32'hFFFF_FFF7, 32'h1234_5670, 32'h1234_5672, 1'b0);

    // Trap entry holds off mret for three cycles
    mret      = 1'b1;
    trap_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("trap_we", 32'(if32.csr_we_o), 32'h0);
      check("trap_addr", 32'(if32.csr_addr_o), 32'h0);
      check("trap_busy_out", 32'(if32.ret_busy_o), 32'h0);
      step();
    end
    trap_busy = 1'b0;
    run_seq(32'h0000_0800, 32'h0000_0040, 32'h0000_1880, 32'h0000_0040, 32'h0000_0040, 1'b0);

    // Reset in WMST: write suppressed, no redirect afterwards
    csr_mst  = 32'h0000_0080;
    csr_mepc = 32'h0000_0300;
    mret     = 1'b1;
    step();
    step();
    rst  = 1'b1;
    mret = 1'b0;
    @(negedge clk);
    check("rstw_we", 32'(if32.csr_we_o), 32'h0);
    check("rstw_addr", 32'(if32.csr_addr_o), 32'h0);
    check("rstw_busy", 32'(if32.ret_busy_o), 32'h0);
    check("rstw_jump", 32'(if32.ret_jump_o), 32'h0);
    step();
    rst = 1'b0;
    repeat (6) step();

    // mret held into cycle 5: second sequence back to back
    begin
      int unsigned c0;
      int unsigned busy_cnt;
      c0       = cyc;
      csr_mst  = 32'h0000_0088;
      csr_mepc = 32'h0000_1002;
      expect_seq(c0, 32'h0000_1888, 32'h0000_1000, 32'h0000_1002);
      expect_seq(c0 + 5, 32'h0000_1888, 32'h0000_1000, 32'h0000_1002);
      mret     = 1'b1;
      busy_cnt = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (if32.ret_busy_o) busy_cnt++;
        if (i == 6) check("b2b_rmst_addr", 32'(if32.csr_addr_o), 32'h300);
        step();
      end
      mret = 1'b0;
      @(negedge clk);
      if (if32.ret_busy_o) busy_cnt++;
      check("b2b_busy_len", busy_cnt, 10);
      step();
    end

    repeat (4) step();
    check("w32_pending", wq32.size(), 0);
    check("j32_pending", jq32.size(), 0);
    check("w16_pending", wq16.size(), 0);
    check("j16_pending", jq16.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
